program_loader: RTL and testbench

Synthesizable program-load and run-control block that sits between a host word stream and the CPU's instruction memory write port. It replaces the bench-side memory preload and fixed-delay finish with a controlled sequence:
- Hold the CPU in reset.
- Stream N words into instruction memory, zero-fill the rest with NOPs.
- Release the CPU for a bounded number of cycles, then halt it and flag completion.

It is parametrised in word width, memory depth and run length, and supports reload and early stop.

---
 rtl/program_loader.sv | 159 +++++++++++++++
 tb/tb_program_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: holds the CPU in reset, streams a program into instruction
// memory, zero-fills the remainder, then runs the CPU for a bounded time.
module program_loader #(
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned INSTR_MEM_SIZE = 32,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned RUN_CYCLES     = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_start,
    input  logic [ADDR_WIDTH:0]     load_length,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_WIDTH-1:0]   in_data,
    input  logic                    stop,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WORD_WIDTH-1:0]   mem_wdata,
    output logic                    cpu_reset,
    output logic                    busy,
    output logic                    done,
    output logic                    load_error,
    output logic [31:0]             cycle_count
);

    localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0]  MEM_SIZE_L = LEN_WIDTH'(INSTR_MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(INSTR_MEM_SIZE - 1);
    localparam logic [31:0]           RUN_LIMIT  = 32'(RUN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_RUN,
        S_DONE
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   ptr, ptr_next;
    logic [LEN_WIDTH-1:0]    len, len_next;
    logic                    in_ready_next;
    logic                    mem_we_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_next;
    logic [WORD_WIDTH-1:0]   mem_wdata_next;
    logic                    cpu_reset_next;
    logic                    busy_next;
    logic                    done_next;
    logic                    load_error_next;
    logic [31:0]             cycle_count_next;
    logic                    len_ok;
    logic                    last_word;
    logic [31:0]             count_inc;

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            ptr         <= '0;
            len         <= '0;
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_reset   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_error  <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            len         <= len_next;
            in_ready    <= in_ready_next;
            mem_we      <= mem_we_next;
            mem_addr    <= mem_addr_next;
            mem_wdata   <= mem_wdata_next;
            cpu_reset   <= cpu_reset_next;
            busy        <= busy_next;
            done        <= done_next;
            load_error  <= load_error_next;
            cycle_count <= cycle_count_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next       = state;
        ptr_next         = ptr;
        len_next         = len;
        in_ready_next    = 1'b0;
        mem_we_next      = 1'b0;
        mem_addr_next    = mem_addr;
        mem_wdata_next   = mem_wdata;
        cpu_reset_next   = 1'b0;
        load_error_next  = 1'b0;
        cycle_count_next = cycle_count;
        len_ok           = (load_length != '0) && (load_length <= MEM_SIZE_L);
        last_word        = ({1'b0, ptr} == (len - LEN_WIDTH'(1)));
        count_inc        = cycle_count + 32'd1;

        case (state)
            S_IDLE, S_DONE: begin
                if (load_start) begin
                    if (len_ok) begin
                        state_next       = S_LOAD;
                        ptr_next         = '0;
                        len_next         = load_length;
                        cycle_count_next = '0;
                        in_ready_next    = 1'b1;
                    end else begin
                        load_error_next  = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                in_ready_next = 1'b1;
                if (in_valid && in_ready) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = ptr;
                    mem_wdata_next = in_data;
                    ptr_next       = ptr + ADDR_WIDTH'(1);
                    if (last_word) begin
                        in_ready_next = 1'b0;
                        state_next    = (len < MEM_SIZE_L) ? S_FILL : S_RUN;
                    end
                end
            end
            S_FILL: begin
                mem_we_next    = 1'b1;
                mem_addr_next  = ptr;
                mem_wdata_next = '0;
                ptr_next       = ptr + ADDR_WIDTH'(1);
                if (ptr == LAST_ADDR) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // First RUN cycle still carries the final write; CPU is released after it
                cpu_reset_next = 1'b1;
                if (cpu_reset) begin
                    cycle_count_next = count_inc;
                end
                if (stop || (cpu_reset && (RUN_LIMIT != 32'd0) && (count_inc == RUN_LIMIT))) begin
                    state_next     = S_DONE;
                    cpu_reset_next = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next == S_LOAD) || (state_next == S_FILL) || (state_next == S_RUN);
        done_next = (state_next == S_DONE);
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: two instances (bounded run and run-until-stop)
// share stimulus through a select, and memory writes are checked against a queue.
module tb_program_loader;

    localparam int unsigned AW    = 5;
    localparam int unsigned WW    = 32;
    localparam int unsigned DEPTH = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    logic          clock;
    logic          reset;
    logic          sel;
    logic          load_start;
    logic [AW:0]   load_length;
    logic          in_valid;
    logic [WW-1:0] in_data;
    logic          stop;

    logic          a_in_ready, a_mem_we, a_cpu_reset, a_busy, a_done, a_load_error;
    logic [AW-1:0] a_mem_addr;
    logic [WW-1:0] a_mem_wdata;
    logic [31:0]   a_cycle_count;
    logic          b_in_ready, b_mem_we, b_cpu_reset, b_busy, b_done, b_load_error;
    logic [AW-1:0] b_mem_addr;
    logic [WW-1:0] b_mem_wdata;
    logic [31:0]   b_cycle_count;

    logic          in_ready, mem_we, cpu_reset, busy, done, load_error;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic [31:0]   cycle_count;

    wr_t exp_q[$];
    int  n_checks;
    int  n_pass;
    int  cyc;
    int  last_we_cyc;
    int  run_len;
    logic prev_cr;

    program_loader #(.RUN_CYCLES(6)) dut_a (
        .clock(clock), .reset(reset),
        .load_start(load_start & ~sel), .load_length(load_length),
        .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .in_data(in_data),
        .stop(stop & ~sel),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .cpu_reset(a_cpu_reset), .busy(a_busy), .done(a_done),
        .load_error(a_load_error), .cycle_count(a_cycle_count)
    );

    program_loader #(.RUN_CYCLES(0)) dut_b (
        .clock(clock), .reset(reset),
        .load_start(load_start & sel), .load_length(load_length),
        .in_valid(in_valid & sel), .in_ready(b_in_ready), .in_data(in_data),
        .stop(stop & sel),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .cpu_reset(b_cpu_reset), .busy(b_busy), .done(b_done),
        .load_error(b_load_error), .cycle_count(b_cycle_count)
    );

    assign in_ready    = sel ? b_in_ready    : a_in_ready;
    assign mem_we      = sel ? b_mem_we      : a_mem_we;
    assign mem_addr    = sel ? b_mem_addr    : a_mem_addr;
    assign mem_wdata   = sel ? b_mem_wdata   : a_mem_wdata;
    assign cpu_reset   = sel ? b_cpu_reset   : a_cpu_reset;
    assign busy        = sel ? b_busy        : a_busy;
    assign done        = sel ? b_done        : a_done;
    assign load_error  = sel ? b_load_error  : a_load_error;
    assign cycle_count = sel ? b_cycle_count : a_cycle_count;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Write scoreboard and run-window tracking
    always @(negedge clock) begin
        if (reset) begin
            if (mem_we) begin
                last_we_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexp_we", 64'(1), 64'(0));
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e.addr));
                    check("wr_data", 64'(mem_wdata), 64'(e.data));
                end
                if (cpu_reset) check("we_in_run", 64'(1), 64'(0));
            end
            if (cpu_reset && !prev_cr) begin
                check("run_gap", 64'(cyc), 64'(last_we_cyc + 1));
                run_len = 0;
            end
            if (cpu_reset) run_len++;
            prev_cr = cpu_reset;
        end else begin
            prev_cr = 1'b0;
        end
        cyc++;
    end

    task automatic start_load(input logic [AW:0] len);
        @(posedge clock); #1;
        load_start  = 1'b1;
        load_length = len;
        @(posedge clock); #1;
        load_start  = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] w, input logic [AW-1:0] addr);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!in_ready) check("ready_timeout", 64'(0), 64'(1));
        @(posedge clock); #1;
        in_valid = 1'b0;
        exp_q.push_back('{addr: addr, data: w});
    endtask

    task automatic push_fill(input int len);
        for (int a = len; a < int'(DEPTH); a++) exp_q.push_back('{addr: AW'(a), data: '0});
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clock);
        while (!done && n < 300) begin
            n++;
            @(negedge clock);
        end
        check("done", 64'(done), 64'(1));
    endtask

    task automatic run_and_stop(input int n);
        int m;
        m = 0;
        @(negedge clock);
        while (!cpu_reset && m < 100) begin
            m++;
            @(negedge clock);
        end
        check("run_start", 64'(cpu_reset), 64'(1));
        for (int i = 1; i < n; i++) begin
            @(posedge clock); #1;
        end
        stop = 1'b1;
        @(posedge clock); #1;
        stop = 1'b0;
    endtask

    initial begin
        logic [WW-1:0] prog [4];
        prog = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0004};
        n_checks = 0; n_pass = 0; cyc = 0; last_we_cyc = -10; run_len = 0; prev_cr = 1'b0;
        reset = 1'b0; sel = 1'b0; load_start = 1'b0; load_length = '0;
        in_valid = 1'b0; in_data = '0; stop = 1'b0;

        // Reset holds every output low regardless of input activity
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            load_start = ~load_start; in_valid = ~in_valid; stop = ~stop;
            load_length = 6'd4; in_data = 32'hFFFF_FFFF;
            @(negedge clock);
            check("rst_a", 64'(|{a_in_ready, a_mem_we, a_mem_addr, a_mem_wdata, a_cpu_reset,
                                  a_busy, a_done, a_load_error, a_cycle_count}), 64'(0));
            check("rst_b", 64'(|{b_in_ready, b_mem_we, b_mem_addr, b_mem_wdata, b_cpu_reset,
                                  b_busy, b_done, b_load_error, b_cycle_count}), 64'(0));
        end
        @(posedge clock); #1;
        reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; stop = 1'b0;
        @(negedge clock);
        check("post_rst", 64'(|{in_ready, mem_we, cpu_reset, busy, done, load_error, cycle_count}), 64'(0));

        // Basic 4-word load with fill and bounded run
        start_load(6'd4);
        check("busy_load", 64'(busy), 64'(1));
        check("ready_load", 64'(in_ready), 64'(1));
        for (int i = 0; i < 4; i++) send_word(prog[i], AW'(i));
        push_fill(4);
        wait_done();
        check("run_len_basic", 64'(run_len), 64'(6));
        check("count_basic", 64'(cycle_count), 64'(6));
        check("cpu_off_basic", 64'(cpu_reset), 64'(0));
        check("busy_done", 64'(busy), 64'(0));
        check("q_basic", 64'(exp_q.size()), 64'(0));

        // Full-depth load with alternating stalls
        start_load(6'd32);
        check("count_clr", 64'(cycle_count), 64'(0));
        check("done_clr", 64'(done), 64'(0));
        for (int i = 0; i < 32; i++) begin
            send_word($urandom, AW'(i));
            @(posedge clock); #1;
        end
        wait_done();
        check("run_len_full", 64'(run_len), 64'(6));
        check("q_full", 64'(exp_q.size()), 64'(0));

        // Rejected lengths pulse load_error for one cycle; stray in_valid ignored
        in_valid = 1'b1;
        start_load(6'd0);
        @(negedge clock);
        check("err_len0", 64'(load_error), 64'(1));
        check("busy_len0", 64'(busy), 64'(0));
        @(negedge clock);
        check("err_clr0", 64'(load_error), 64'(0));
        start_load(6'd33);
        @(negedge clock);
        check("err_len33", 64'(load_error), 64'(1));
        @(negedge clock);
        check("err_clr33", 64'(load_error), 64'(0));
        check("ready_idle", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        repeat (3) @(negedge clock);

        // Early stop on the run-until-stop instance, then reload
        sel = 1'b1;
        start_load(6'd1);
        send_word(32'hDEADBEEF, AW'(0));
        push_fill(1);
        run_and_stop(3);
        @(negedge clock);
        check("stop_done", 64'(done), 64'(1));
        check("stop_cpu", 64'(cpu_reset), 64'(0));
        check("stop_count", 64'(cycle_count), 64'(3));
        check("stop_run_len", 64'(run_len), 64'(3));
        start_load(6'd2);
        check("reload_count", 64'(cycle_count), 64'(0));
        check("reload_done", 64'(done), 64'(0));
        send_word(32'h1234_5678, AW'(0));
        send_word(32'h9ABC_DEF0, AW'(1));
        push_fill(2);
        run_and_stop(5);
        @(negedge clock);
        check("stop2_count", 64'(cycle_count), 64'(5));
        check("stop2_done", 64'(done), 64'(1));
        check("q_stop", 64'(exp_q.size()), 64'(0));
        sel = 1'b0;

        // Asynchronous reset in the middle of a load
        start_load(6'd4);
        send_word(prog[0], AW'(0));
        send_word(prog[1], AW'(1));
        #2 reset = 1'b0;
        #1;
        check("arst_we", 64'(mem_we), 64'(0));
        check("arst_ready", 64'(in_ready), 64'(0));
        check("arst_cpu", 64'(cpu_reset), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rel_busy", 64'(busy), 64'(0));
        check("rel_done", 64'(done), 64'(0));
        start_load(6'd4);
        for (int i = 0; i < 4; i++) send_word(prog[3 - i], AW'(i));
        push_fill(4);
        wait_done();
        check("q_reload", 64'(exp_q.size()), 64'(0));
        check("count_reload", 64'(cycle_count), 64'(6));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
